uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_framer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional even/odd parity,
// one or two stop bits. Each bit is held CLKS_PER_BIT clocks; every output is registered.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, tx_ready=1, waiting for tx_valid
// S_START  | driving the start bit (0) for one bit time
// S_DATA   | driving data bit bit_q of the latched word, LSB first
// S_PARITY | driving the parity bit computed from the latched word
// S_STOP   | driving stop bit(s) (1); bit_q counts the second stop bit
module uart_tx_framer #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic [DATA_BITS-1:0] data_q;
   logic [1:0]           pmode_q;
   logic                 stop2_q;
   logic                 serial_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 baud_tick;
   logic                 par_en;
   logic                 par_bit;
   logic [BIT_W-1:0]     bit_nxt;

   assign baud_tick = (baud_q == BAUD_LAST);
   assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
   // odd parity is the inverse of the plain XOR of the word
   assign par_bit   = (^data_q) ^ (pmode_q == 2'b10);
   assign bit_nxt   = bit_q + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         pmode_q  <= 2'b00;
         stop2_q  <= 1'b0;
         serial_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               bit_q  <= '0;
               if (tx_valid) begin
                  data_q   <= tx_data;
                  pmode_q  <= parity_mode;
                  stop2_q  <= stop2;
                  state_q  <= S_START;
                  serial_q <= 1'b0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  baud_q   <= '0;
                  state_q  <= S_DATA;
                  serial_q <= data_q[0];
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  baud_q <= '0;
                  if (bit_q == LAST_BIT) begin
                     bit_q <= '0;
                     if (par_en) begin
                        state_q  <= S_PARITY;
                        serial_q <= par_bit;
                     end else begin
                        state_q  <= S_STOP;
                        serial_q <= 1'b1;
                     end
                  end else begin
                     bit_q    <= bit_nxt;
                     serial_q <= data_q[bit_nxt];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (baud_tick) begin
                  baud_q   <= '0;
                  state_q  <= S_STOP;
                  serial_q <= 1'b1;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_tick) begin
                  baud_q <= '0;
                  if (stop2_q && (bit_q == '0)) begin
                     bit_q <= 1'b1;
                  end else begin
                     bit_q    <= '0;
                     state_q  <= S_IDLE;
                     serial_q <= 1'b1;
                     ready_q  <= 1'b1;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               baud_q   <= '0;
               bit_q    <= '0;
               serial_q <= 1'b1;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready  = ready_q;
   assign tx_serial = serial_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: table of frames checked cycle-by-cycle through an
// expected-line queue, plus hand sequences for back-to-back, reset abort and 7-bit data.
module tb_uart_tx_framer;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic [1:0] parity_mode = '0;
   logic       stop2 = 1'b0;
   logic       tx_ready, tx_serial, tx_busy, tx_done;

   logic [6:0] d7_data = '0;
   logic       d7_valid = 1'b0;
   logic [1:0] d7_pmode = '0;
   logic       d7_stop2 = 1'b0;
   logic       d7_ready, d7_serial, d7_busy, d7_done;

   uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .parity_mode(parity_mode), .stop2(stop2), .tx_ready(tx_ready),
      .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done));

   uart_tx_framer #(.DATA_BITS(7), .CLKS_PER_BIT(CPB)) dut7 (
      .clk(clk), .reset_n(reset_n), .tx_data(d7_data), .tx_valid(d7_valid),
      .parity_mode(d7_pmode), .stop2(d7_stop2), .tx_ready(d7_ready),
      .tx_serial(d7_serial), .tx_busy(d7_busy), .tx_done(d7_done));

   always #5 clk = ~clk;

   typedef struct {
      logic serial;
      logic busy;
      logic done;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] pmode;
      logic       stop2;
      logic       par_on;
      logic       par_bit;
      int         len;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   logic idle_chk = 1'b0;
   vec_t vec[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   task automatic push_bit(input logic v);
      for (int c = 0; c < CPB; c++) exp_q.push_back('{serial: v, busy: 1'b1, done: 1'b0});
   endtask

   task automatic push_frame(input logic [7:0] d, input logic par_on, input logic pb,
                             input logic s2);
      push_bit(1'b0);
      for (int b = 0; b < 8; b++) push_bit(d[b]);
      if (par_on) push_bit(pb);
      push_bit(1'b1);
      if (s2) push_bit(1'b1);
      exp_q.push_back('{serial: 1'b1, busy: 1'b0, done: 1'b1});
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("line", tx_serial, mon_e.serial);
         chk("busy", tx_busy, mon_e.busy);
         chk("done", tx_done, mon_e.done);
         chk("ready", tx_ready, !mon_e.busy);
      end else if (idle_chk) begin
         chk("idle_line", tx_serial, 1'b1);
         chk("idle_busy", tx_busy, 1'b0);
         chk("idle_done", tx_done, 1'b0);
         chk("idle_ready", tx_ready, 1'b1);
      end
      if (tx_busy) busy_cnt++;
   end

   initial begin
      logic [9:0] exp7;

      // parity bits and lengths worked out by hand for each word
      vec[0] = '{8'hA5, 2'b01, 1'b0, 1'b1, 1'b0, 44};
      vec[1] = '{8'hA5, 2'b10, 1'b0, 1'b1, 1'b1, 44};
      vec[2] = '{8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 44};
      vec[3] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 40};
      vec[4] = '{8'h5A, 2'b01, 1'b1, 1'b1, 1'b0, 48};
      vec[5] = '{8'h01, 2'b10, 1'b1, 1'b1, 1'b0, 48};
      vec[6] = '{8'h80, 2'b01, 1'b0, 1'b1, 1'b1, 44};

      repeat (3) @(negedge clk);
      chk("rst_line", tx_serial, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      reset_n = 1'b1;
      idle_chk = 1'b1;

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         tx_data = vec[i].data;
         parity_mode = vec[i].pmode;
         stop2 = vec[i].stop2;
         tx_valid = 1'b1;
         busy_cnt = 0;
         @(posedge clk);
         #1;
         push_frame(vec[i].data, vec[i].par_on, vec[i].par_bit, vec[i].stop2);
         // junk on every input while busy must not disturb the frame
         tx_valid = 1'b0;
         tx_data = 8'($urandom);
         parity_mode = 2'($urandom);
         stop2 = 1'($urandom);
         repeat (3) @(posedge clk);
         #1 tx_valid = 1'b1;
         repeat (vec[i].len - 8) @(posedge clk);
         #1 tx_valid = 1'b0;
         wait_drain(200);
         chk("frame_len", busy_cnt, vec[i].len);
         repeat (2) @(negedge clk);
      end

      // back-to-back with tx_valid held high
      @(negedge clk);
      tx_data = 8'h3C;
      parity_mode = 2'b00;
      stop2 = 1'b0;
      tx_valid = 1'b1;
      busy_cnt = 0;
      @(posedge clk);
      #1;
      push_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      tx_data = 8'hC3;
      repeat (41) @(posedge clk);
      #1;
      push_frame(8'hC3, 1'b0, 1'b0, 1'b0);
      tx_valid = 1'b0;
      wait_drain(200);
      chk("b2b_busy_len", busy_cnt, 80);
      repeat (2) @(negedge clk);

      // reset in the middle of a frame
      idle_chk = 1'b0;
      @(negedge clk);
      tx_data = 8'h00;
      parity_mode = 2'b00;
      stop2 = 1'b0;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      chk("pre_rst_line", tx_serial, 1'b0);
      chk("pre_rst_busy", tx_busy, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("abort_line", tx_serial, 1'b1);
      chk("abort_ready", tx_ready, 1'b1);
      chk("abort_busy", tx_busy, 1'b0);
      chk("abort_done", tx_done, 1'b0);
      idle_chk = 1'b1;
      repeat (3) @(negedge clk);

      // first accept on the first edge after reset release
      tx_data = 8'h96;
      parity_mode = 2'b01;
      stop2 = 1'b1;
      tx_valid = 1'b1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      push_frame(8'h96, 1'b1, 1'b0, 1'b1);
      tx_valid = 1'b0;
      wait_drain(200);
      repeat (2) @(negedge clk);
      idle_chk = 1'b0;

      // 7-bit instance: 0x7F, even parity
      exp7 = 10'b11_1111_1110;
      @(negedge clk);
      d7_data = 7'h7F;
      d7_pmode = 2'b01;
      d7_stop2 = 1'b0;
      d7_valid = 1'b1;
      @(posedge clk);
      #1 d7_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         chk("d7_line", d7_serial, exp7[c / CPB]);
         chk("d7_busy", d7_busy, 1'b1);
      end
      @(negedge clk);
      chk("d7_done", d7_done, 1'b1);
      chk("d7_idle_busy", d7_busy, 1'b0);
      @(negedge clk);
      chk("d7_done_pulse", d7_done, 1'b0);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
